// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with integrated load-use hazard detection, Hold and Flush.
// Optional build macro ID_EX_PERF_CNT_EN adds saturating stall/flush performance counters.
module id_ex_reg #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 3,
  parameter int ALUOP_W  = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Hold,
  input  logic               Flush,
  input  logic               ID_Valid,
  input  logic               ID_RegDst,
  input  logic               ID_ALUSrc,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_RegWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_UsesRt,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [REG_AW-1:0]  ID_Rs,
  input  logic [REG_AW-1:0]  ID_Rt,
  input  logic [REG_AW-1:0]  ID_Rd,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  output logic               EX_Valid,
  output logic               EX_RegDst,
  output logic               EX_ALUSrc,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_RegWrite,
  output logic               EX_MemToReg,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic [REG_AW-1:0]  EX_Rs,
  output logic [REG_AW-1:0]  EX_Rt,
  output logic [REG_AW-1:0]  EX_Rd,
  output logic [DATA_W-1:0]  EX_ReadData1,
  output logic [DATA_W-1:0]  EX_ReadData2,
  output logic [DATA_W-1:0]  EX_Imm,
`ifdef ID_EX_PERF_CNT_EN
  output logic [15:0]        StallCount,
  output logic [15:0]        FlushCount,
`endif
  output logic               Stall
);

  localparam int CTRL_W = 6 + ALUOP_W;

  // ---------------------------------------------------------------------------
  // Load-use hazard detection (purely combinational on current EX and ID)
  // ---------------------------------------------------------------------------
  logic rsMatch;
  logic rtMatch;

  generate
    if (ZERO_REG) begin : g_zeroReg
      // Register 0 always reads zero, so a load "into" it can never be a source.
      assign rsMatch = (EX_Rt == ID_Rs) && (EX_Rt != '0);
      assign rtMatch = (EX_Rt == ID_Rt) && (EX_Rt != '0);
    end else begin : g_plainReg
      assign rsMatch = (EX_Rt == ID_Rs);
      assign rtMatch = (EX_Rt == ID_Rt);
    end
  endgenerate

  assign Stall = ID_Valid & EX_Valid & EX_MemRead & ~Flush &
                 (rsMatch | (ID_UsesRt & rtMatch));

  // ---------------------------------------------------------------------------
  // Update decision: bubble, freeze or load
  // ---------------------------------------------------------------------------
  logic loadBubble;
  logic loadId;

  assign loadBubble = Flush | (~Hold & Stall);
  assign loadId     = ~Flush & ~Hold & ~Stall;

  // ---------------------------------------------------------------------------
  // Valid and control fields
  // ---------------------------------------------------------------------------
  logic              validReg;
  logic              validNext;
  logic [CTRL_W-1:0] ctrlReg;
  logic [CTRL_W-1:0] ctrlNext;
  logic [CTRL_W-1:0] idCtrl;

  assign idCtrl = {ID_ALUOp, ID_MemToReg, ID_RegWrite, ID_MemWrite,
                   ID_MemRead, ID_ALUSrc, ID_RegDst};

  // ALUOp travels with the controls so an invalid slot carries no opcode either.
  always_comb begin
    validNext = validReg;
    ctrlNext  = ctrlReg;
    if (loadBubble) begin
      validNext = 1'b0;
      ctrlNext  = '0;
    end else if (loadId) begin
      validNext = ID_Valid;
      ctrlNext  = ID_Valid ? idCtrl : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validReg <= 1'b0;
      ctrlReg  <= '0;
    end else begin
      validReg <= validNext;
      ctrlReg  <= ctrlNext;
    end
  end

  assign EX_Valid = validReg;
  assign {EX_ALUOp, EX_MemToReg, EX_RegWrite, EX_MemWrite,
          EX_MemRead, EX_ALUSrc, EX_RegDst} = ctrlReg;

  // ---------------------------------------------------------------------------
  // Register-number and operand lanes; these load even when ID_Valid is low
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] idRegNum [3];
  logic [REG_AW-1:0] exRegNum [3];
  logic [DATA_W-1:0] idData   [3];
  logic [DATA_W-1:0] exData   [3];

  assign idRegNum[0] = ID_Rs;
  assign idRegNum[1] = ID_Rt;
  assign idRegNum[2] = ID_Rd;
  assign idData[0]   = ID_ReadData1;
  assign idData[1]   = ID_ReadData2;
  assign idData[2]   = ID_Imm;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic [REG_AW-1:0] regNumReg;
      logic [REG_AW-1:0] regNumNext;
      logic [DATA_W-1:0] dataReg;
      logic [DATA_W-1:0] dataNext;

      always_comb begin
        regNumNext = regNumReg;
        dataNext   = dataReg;
        if (loadBubble) begin
          regNumNext = '0;
          dataNext   = '0;
        end else if (loadId) begin
          regNumNext = idRegNum[gi];
          dataNext   = idData[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          regNumReg <= '0;
          dataReg   <= '0;
        end else begin
          regNumReg <= regNumNext;
          dataReg   <= dataNext;
        end
      end

      assign exRegNum[gi] = regNumReg;
      assign exData[gi]   = dataReg;
    end
  endgenerate

  assign EX_Rs        = exRegNum[0];
  assign EX_Rt        = exRegNum[1];
  assign EX_Rd        = exRegNum[2];
  assign EX_ReadData1 = exData[0];
  assign EX_ReadData2 = exData[1];
  assign EX_Imm       = exData[2];

`ifdef ID_EX_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating counters; Stall already excludes Flush, so the two never overlap
  // ---------------------------------------------------------------------------
  logic [15:0] stallCntReg;
  logic [15:0] stallCntNext;
  logic [15:0] flushCntReg;
  logic [15:0] flushCntNext;

  always_comb begin
    stallCntNext = stallCntReg;
    flushCntNext = flushCntReg;
    if (~Hold && Stall && (stallCntReg != 16'hFFFF)) begin
      stallCntNext = stallCntReg + 16'd1;
    end
    if (Flush && (flushCntReg != 16'hFFFF)) begin
      flushCntNext = flushCntReg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntReg <= '0;
      flushCntReg <= '0;
    end else begin
      stallCntReg <= stallCntNext;
      flushCntReg <= flushCntNext;
    end
  end

  assign StallCount = stallCntReg;
  assign FlushCount = flushCntReg;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a behavioural model predicts each edge, results are queued and popped.
// Runs the ZERO_REG=1 design as primary and a ZERO_REG=0 copy for the zero-register comparison.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic        regDst;
    logic        aluSrc;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic        memToReg;
    logic [2:0]  aluOp;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
  } exState_t;

  // control bundles: {memToReg, regWrite, memWrite, memRead, aluSrc, regDst}
  localparam logic [5:0] CTL_LOAD  = 6'b110110;
  localparam logic [5:0] CTL_RTYPE = 6'b010001;
  localparam logic [5:0] CTL_STORE = 6'b001010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, Hold, Flush, ID_Valid;
  logic ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemToReg, ID_UsesRt;
  logic [2:0]  ID_ALUOp, ID_Rs, ID_Rt, ID_Rd;
  logic [15:0] ID_ReadData1, ID_ReadData2, ID_Imm;

  logic EX_Valid, EX_RegDst, EX_ALUSrc, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemToReg, Stall;
  logic [2:0]  EX_ALUOp, EX_Rs, EX_Rt, EX_Rd;
  logic [15:0] EX_ReadData1, EX_ReadData2, EX_Imm;

  logic xValid, xRegDst, xALUSrc, xMemRead, xMemWrite, xRegWrite, xMemToReg, xStall;
  logic [2:0]  xALUOp, xRs, xRt, xRd;
  logic [15:0] xReadData1, xReadData2, xImm;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] StallCount, FlushCount, xStallCount, xFlushCount;
`endif

  id_ex_reg #(.DATA_W(16), .REG_AW(3), .ALUOP_W(3), .ZERO_REG(1'b1)) u_dut (
    .clk(clk), .rst(rst), .Hold(Hold), .Flush(Flush), .ID_Valid(ID_Valid),
    .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_RegWrite(ID_RegWrite), .ID_MemToReg(ID_MemToReg),
    .ID_UsesRt(ID_UsesRt), .ID_ALUOp(ID_ALUOp), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .EX_Valid(EX_Valid), .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .EX_ALUOp(EX_ALUOp), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
`ifdef ID_EX_PERF_CNT_EN
    .StallCount(StallCount), .FlushCount(FlushCount),
`endif
    .Stall(Stall)
  );

  id_ex_reg #(.DATA_W(16), .REG_AW(3), .ALUOP_W(3), .ZERO_REG(1'b0)) u_dutNoZero (
    .clk(clk), .rst(rst), .Hold(Hold), .Flush(Flush), .ID_Valid(ID_Valid),
    .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_RegWrite(ID_RegWrite), .ID_MemToReg(ID_MemToReg),
    .ID_UsesRt(ID_UsesRt), .ID_ALUOp(ID_ALUOp), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .EX_Valid(xValid), .EX_RegDst(xRegDst), .EX_ALUSrc(xALUSrc), .EX_MemRead(xMemRead),
    .EX_MemWrite(xMemWrite), .EX_RegWrite(xRegWrite), .EX_MemToReg(xMemToReg),
    .EX_ALUOp(xALUOp), .EX_Rs(xRs), .EX_Rt(xRt), .EX_Rd(xRd),
    .EX_ReadData1(xReadData1), .EX_ReadData2(xReadData2), .EX_Imm(xImm),
`ifdef ID_EX_PERF_CNT_EN
    .StallCount(xStallCount), .FlushCount(xFlushCount),
`endif
    .Stall(xStall)
  );

  int numChecks = 0;
  int numPassed = 0;

  exState_t model;
  exState_t expQ[$];
  int mStallCnt = 0;
  int mFlushCnt = 0;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    numChecks++;
    if (got === exp) numPassed++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  function automatic bit regMatch(input logic [2:0] a, input logic [2:0] b, input bit zr);
    return (a == b) && !(zr && (a == 3'd0));
  endfunction

  function automatic bit modelStall(input bit zr);
    return ID_Valid && model.valid && model.memRead && !Flush &&
           (regMatch(model.rt, ID_Rs, zr) || (ID_UsesRt && regMatch(model.rt, ID_Rt, zr)));
  endfunction

  function automatic exState_t dutState();
    return {EX_Valid, EX_RegDst, EX_ALUSrc, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemToReg,
            EX_ALUOp, EX_Rs, EX_Rt, EX_Rd, EX_ReadData1, EX_ReadData2, EX_Imm};
  endfunction

  task automatic setId(input logic v, input logic [5:0] ctl, input logic [2:0] op,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic ur, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c);
    ID_Valid = v;
    {ID_MemToReg, ID_RegWrite, ID_MemWrite, ID_MemRead, ID_ALUSrc, ID_RegDst} = ctl;
    ID_ALUOp = op; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_UsesRt = ur;
    ID_ReadData1 = a; ID_ReadData2 = b; ID_Imm = c;
  endtask

  task automatic setCtl(input logic r, input logic h, input logic f);
    rst = r; Hold = h; Flush = f;
  endtask

  // One clock: check Stall, predict the edge, push, clock, pop and compare.
  task automatic step(input string tag, input bit chkStall, input bit chkNoZero);
    exState_t nxt;
    exState_t got;
    bit st;
    #1;
    st = modelStall(1'b1);
    if (chkStall) check({tag, ".stall"}, 67'(Stall), 67'(st));
    if (chkNoZero) check({tag, ".stallZr0"}, 67'(xStall), 67'(modelStall(1'b0)));
    if (rst) begin
      nxt = '0;
      mStallCnt = 0;
      mFlushCnt = 0;
    end else if (Flush) begin
      nxt = '0;
      if (mFlushCnt < 65535) mFlushCnt++;
    end else if (Hold) begin
      nxt = model;
    end else if (st) begin
      nxt = '0;
      if (mStallCnt < 65535) mStallCnt++;
    end else begin
      nxt = {ID_Valid, ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemToReg,
             ID_ALUOp, ID_Rs, ID_Rt, ID_Rd, ID_ReadData1, ID_ReadData2, ID_Imm};
      if (!ID_Valid) begin
        nxt.regDst = 0; nxt.aluSrc = 0; nxt.memRead = 0; nxt.memWrite = 0;
        nxt.regWrite = 0; nxt.memToReg = 0; nxt.aluOp = '0;
      end
    end
    model = nxt;
    expQ.push_back(nxt);
    @(posedge clk);
    #1;
    got = dutState();
    check({tag, ".ex"}, got, expQ.pop_front());
`ifdef ID_EX_PERF_CNT_EN
    check({tag, ".stallCnt"}, 67'(StallCount), 67'(mStallCnt));
    check({tag, ".flushCnt"}, 67'(FlushCount), 67'(mFlushCnt));
`endif
  endtask

  initial begin
    model = '0;
    // reset with busy ID inputs
    setCtl(1, 0, 0);
    setId(1, CTL_LOAD, 3'd5, 3'd2, 3'd2, 3'd7, 1, 16'h1234, 16'h5678, 16'h9ABC);
    step("reset0", 0, 0);
    step("reset1", 1, 0);

    setCtl(0, 0, 0);
    setId(1, CTL_RTYPE, 3'd2, 3'd1, 3'd2, 3'd3, 1, 16'h1111, 16'h2222, 16'hFFFF);
    step("passThru", 1, 0);

    // load-use on Rs costs exactly one bubble
    setId(1, CTL_LOAD, 3'd0, 3'd1, 3'd2, 3'd0, 0, 16'h0040, 16'h0000, 16'h0004);
    step("load", 1, 0);
    setId(1, CTL_RTYPE, 3'd1, 3'd2, 3'd3, 3'd4, 1, 16'h0001, 16'h0002, 16'h0000);
    step("useStall", 1, 0);
    step("useLoad", 1, 0);

    // back-to-back loads into the same register, then one dependent consumer
    setId(1, CTL_LOAD, 3'd0, 3'd1, 3'd4, 3'd0, 0, 16'h0010, 16'h0000, 16'h0002);
    step("ldA", 1, 0);
    setId(1, CTL_LOAD, 3'd0, 3'd5, 3'd4, 3'd0, 0, 16'h0020, 16'h0000, 16'h0006);
    step("ldB", 1, 0);
    setId(1, CTL_RTYPE, 3'd3, 3'd4, 3'd1, 3'd6, 1, 16'h0aaa, 16'h0bbb, 16'h0000);
    step("b2bStall", 1, 0);
    step("b2bLoad", 1, 0);

    // Rt-side dependency only counts when the instruction reads Rt
    setId(1, CTL_LOAD, 3'd0, 3'd1, 3'd6, 3'd0, 0, 16'h0030, 16'h0000, 16'h0001);
    step("ldRt", 1, 0);
    setId(1, CTL_STORE, 3'd0, 3'd1, 3'd6, 3'd0, 1, 16'h0031, 16'h0032, 16'h0003);
    step("rtStall", 1, 0);
    step("rtLoad", 1, 0);

    // invalid ID slot: controls cleared, data still loads
    setId(0, CTL_LOAD, 3'd6, 3'd3, 3'd5, 3'd7, 1, 16'hBEEF, 16'hCAFE, 16'h0F0F);
    step("invalidId", 1, 0);

    // hold freezes EX while Stall is still reported; flush overrides hold
    setId(1, CTL_LOAD, 3'd0, 3'd1, 3'd2, 3'd0, 0, 16'hAAAA, 16'h0000, 16'h0008);
    step("holdSetup", 1, 0);
    setCtl(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      setId(1, CTL_RTYPE, 3'(i), 3'd2, 3'(i), 3'd5, 1, 16'(i), 16'h0, 16'h0);
      step("hold", 1, 0);
    end
    setCtl(0, 1, 1);
    step("holdFlush", 1, 0);
    setCtl(0, 0, 1);
    setId(1, CTL_RTYPE, 3'd4, 3'd1, 3'd2, 3'd3, 1, 16'h7777, 16'h8888, 16'h9999);
    step("flush", 1, 0);

    // reset arriving while a stall is being raised
    setCtl(0, 0, 0);
    setId(1, CTL_LOAD, 3'd0, 3'd1, 3'd3, 3'd0, 0, 16'h0050, 16'h0000, 16'h0000);
    step("rstStallSetup", 1, 0);
    setId(1, CTL_RTYPE, 3'd1, 3'd3, 3'd1, 3'd2, 1, 16'h0001, 16'h0002, 16'h0000);
    setCtl(1, 0, 0);
    step("rstMidStall", 1, 0);
    setCtl(0, 0, 0);
    step("afterRst", 1, 0);

    // zero register: only the ZERO_REG=0 copy stalls
    setCtl(1, 0, 0);
    step("zrReset", 1, 0);
    setCtl(0, 0, 0);
    setId(1, CTL_LOAD, 3'd0, 3'd1, 3'd0, 3'd0, 0, 16'h0060, 16'h0000, 16'h0000);
    step("zrLoad", 1, 0);
    setId(1, CTL_RTYPE, 3'd1, 3'd0, 3'd1, 3'd2, 0, 16'h0003, 16'h0004, 16'h0000);
    step("zrUse", 1, 1);
    setCtl(1, 0, 0);
    step("zrResync", 1, 0);

    // random traffic with small register numbers to provoke hazards
    for (int n = 0; n < 200; n++) begin
      setCtl(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 7) == 0));
      setId(($urandom_range(0, 5) != 0), 6'($urandom), 3'($urandom),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom),
            1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      step("rand", 1, 0);
    end

`ifdef ID_EX_PERF_CNT_EN
    // two load-use stalls and one flush from a clean start
    setCtl(1, 0, 0);
    step("cntReset", 1, 0);
    setCtl(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      setId(1, CTL_LOAD, 3'd0, 3'd1, 3'd2, 3'd0, 0, 16'h0100, 16'h0000, 16'h0000);
      step("cntLoad", 1, 0);
      setId(1, CTL_RTYPE, 3'd1, 3'd2, 3'd1, 3'd3, 1, 16'h0001, 16'h0001, 16'h0000);
      step("cntStall", 1, 0);
      step("cntUse", 1, 0);
    end
    setCtl(0, 0, 1);
    step("cntFlush", 1, 0);
    check("stallCount2", 67'(StallCount), 67'd2);
    check("flushCount1", 67'(FlushCount), 67'd1);
    // drive the flush counter into saturation
    for (int k = 0; k < 65540; k++) step("cntSat", 1, 0);
    check("flushCountSat", 67'(FlushCount), 67'h0FFFF);
`endif

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 16-bit pipelined processor. Sits between decode and the EX-stage operand/destination muxes, and feeds them:
  - control: RegDst, ALUSrc
  - register numbers: Rs, Rt, Rd
  - operands: ReadData1, ReadData2, Imm
- Integrates load-use hazard detection. When the instruction in ID needs the result of a load now in EX, it raises Stall and inserts one bubble.
- Honours a pipeline-wide Hold (freeze) and a branch Flush (squash).

Parameters:
- DATA_W, 16, operand/immediate width
- REG_AW, 3, register-number width (8 registers)
- ALUOP_W, 3, ALU opcode width
- ZERO_REG, 1, 1 = register 0 is hardwired zero and never causes a hazard

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- Hold  in  1  freeze entire register (e.g. memory wait)
- Flush  in  1  squash instruction entering EX (branch taken)
- ID_Valid  in  1  ID holds a real instruction
- ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_MemToReg  in  1 each  decoded controls
- ID_UsesRt  in  1  ID instruction reads Rt as a source
- ID_ALUOp  in  ALUOP_W  ALU opcode
- ID_Rs, ID_Rt, ID_Rd  in  REG_AW each  register numbers
- ID_ReadData1, ID_ReadData2, ID_Imm  in  DATA_W each  register-file reads, sign-extended immediate
- EX_Valid  out  1  EX holds a real instruction
- EX_RegDst, EX_ALUSrc, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemToReg  out  1 each  registered controls
- EX_ALUOp  out  ALUOP_W
- EX_Rs, EX_Rt, EX_Rd  out  REG_AW each
- EX_ReadData1, EX_ReadData2, EX_Imm  out  DATA_W each
- Stall  out  1  combinational; holds PC and IF/ID this cycle

Behaviour:
- Reset: every registered output is 0 on the first rising edge with rst=1. EX_Valid=0 and all controls are 0, so EX holds a bubble.
- Latency: 1 cycle. ID_* values sampled at edge N appear on EX_* after edge N.
- Hazard:
  - Stall = ID_Valid & EX_Valid & EX_MemRead & !Flush & (EX_Rt==ID_Rs | (ID_UsesRt & EX_Rt==ID_Rt)).
  - If ZERO_REG=1, a comparison against register 0 never matches.
  - Stall is purely combinational from current EX_* and ID_* values; there is no extra state.
- Update priority at each rising edge (highest first):
  1. rst: all outputs cleared.
  2. Flush: load a bubble (all EX_* = 0). Flush overrides Hold.
  3. Hold: all EX_* keep their value. Stall is still reported.
  4. Stall: load a bubble (all EX_* = 0). The stalled ID instruction is re-presented next cycle by the upstream stage.
  5. Otherwise: load ID_*. EX_Valid=ID_Valid. If ID_Valid=0, all controls are forced to 0 but data fields still load.
- Bubble definition: EX_Valid, EX_RegWrite, EX_MemRead and EX_MemWrite are 0, and all other fields are 0 for determinism.
- A load followed by a dependent instruction costs exactly one bubble. After the bubble EX_MemRead=0, so Stall drops and forwarding covers the rest.
- Back-to-back loads into the same register stall once per dependent consumer only.
- Reset mid-stall: Stall drops on the cycle after reset because EX_Valid=0.

Optional Feature:
- ID_EX_PERF_CNT_EN defined: adds output StallCount [15:0] and output FlushCount [15:0].
  - StallCount increments on each edge where a Stall bubble is loaded.
  - FlushCount increments on each edge where a Flush bubble is loaded.
  - Both counters saturate at 16'hFFFF, are cleared by rst, and do not count while Hold=1 (unless Flush, which still counts).
- Macro undefined: neither port nor the counters exist. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with ID_* nonzero -> all EX_* = 0 and Stall=0.
- Pass-through: ID_Valid=1, RegDst=1, ALUSrc=0, Rs=1, Rt=2, Rd=3, ReadData1=16'h1111, ReadData2=16'h2222, Imm=16'hFFFF -> identical values on EX_* after one edge; Stall=0.
- Load-use: EX holds a load with Rt=2 (MemRead=1, Valid=1), ID_Rs=2 -> Stall=1. Next edge EX_Valid=0, EX_RegWrite=0. Following edge the dependent instruction loads, Stall=0.
- Zero register: EX load with Rt=0, ID_Rs=0, ZERO_REG=1 -> Stall=0. Same stimulus with ZERO_REG=0 -> Stall=1.
- Hold vs Flush: EX holds ReadData1=16'hAAAA; Hold=1 for 3 cycles -> EX_ReadData1 stays 16'hAAAA. Then Hold=1 and Flush=1 together -> bubble loaded; EX_Valid=0.
- Counters (ID_EX_PERF_CNT_EN): 2 load-use stalls and 1 flush -> StallCount=2, FlushCount=1. Counter preset near the limit -> stays at 16'hFFFF.
